// File: rtl/lcd_bus_decoder.sv
// Receive side of an 8080-style LCD bus: synchronizes the strobes, decodes
// CASET/PASET/RAMWR/SWRESET and emits windowed pixel writes with coordinates.
module lcd_bus_decoder #(
  parameter int H_RES = 240,
  parameter int V_RES = 320,
  parameter int CW    = 16
) (
  input  logic          i_clk,
  input  logic          i_reset_n,
  input  logic [15:0]   i_lcd_data,
  input  logic          i_lcd_dc,
  input  logic          i_lcd_wr,
  input  logic          i_lcd_rd,
  input  logic          i_lcd_reset_n,
  output logic          o_pix_valid,
  output logic [CW-1:0] o_pix_x,
  output logic [CW-1:0] o_pix_y,
  output logic [15:0]   o_pix_data,
  output logic          o_cmd_valid,
  output logic [7:0]    o_cmd_code,
  output logic          o_frame_done,
  output logic          o_err_win,
  output logic          o_err_rd
);

  typedef enum logic [1:0] {S_IDLE, S_CASET, S_PASET, S_RAMWR} state_t;

  logic          r_wr_s1, r_wr_s2, r_wr_s3;
  logic          r_dc_s1, r_dc_s2;
  logic [15:0]   r_data_s1, r_data_s2;
  logic          r_rd_s1, r_rd_s2;
  logic          r_lrst_s1, r_lrst_s2;

  state_t        r_state;
  logic [1:0]    r_idx;
  logic [7:0]    r_p0, r_p1, r_p2;
  logic [CW-1:0] r_sc, r_ec, r_sp, r_ep, r_x, r_y;

  logic          w_evt, w_cmd, w_dat, w_win_ok, w_in_bounds, w_last_col, w_last_row;
  logic [15:0]   w_start, w_end;

  // Strobe/data synchronizers; idle levels avoid a false edge or read error after reset.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_wr_s1   <= 1'b1;
      r_wr_s2   <= 1'b1;
      r_wr_s3   <= 1'b1;
      r_dc_s1   <= 1'b0;
      r_dc_s2   <= 1'b0;
      r_data_s1 <= 16'h0000;
      r_data_s2 <= 16'h0000;
      r_rd_s1   <= 1'b1;
      r_rd_s2   <= 1'b1;
      r_lrst_s1 <= 1'b0;
      r_lrst_s2 <= 1'b0;
    end else begin
      r_wr_s1   <= i_lcd_wr;
      r_wr_s2   <= r_wr_s1;
      r_wr_s3   <= r_wr_s2;
      r_dc_s1   <= i_lcd_dc;
      r_dc_s2   <= r_dc_s1;
      r_data_s1 <= i_lcd_data;
      r_data_s2 <= r_data_s1;
      r_rd_s1   <= i_lcd_rd;
      r_rd_s2   <= r_rd_s1;
      r_lrst_s1 <= i_lcd_reset_n;
      r_lrst_s2 <= r_lrst_s1;
    end
  end

  assign w_evt       = r_wr_s2 & ~r_wr_s3 & r_lrst_s2;
  assign w_cmd       = w_evt & ~r_dc_s2;
  assign w_dat       = w_evt & r_dc_s2;
  assign w_win_ok    = (r_sc <= r_ec) && (r_sp <= r_ep);
  assign w_in_bounds = (r_x < CW'(H_RES)) && (r_y < CW'(V_RES));
  assign w_last_col  = (r_x == r_ec);
  assign w_last_row  = (r_y == r_ep);
  assign w_start     = {r_p0, r_p1};
  assign w_end       = {r_p2, r_data_s2[7:0]};

  // Command decode, window parameter assembly and pixel cursor.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state      <= S_IDLE;
      r_idx        <= 2'd0;
      r_p0         <= 8'h00;
      r_p1         <= 8'h00;
      r_p2         <= 8'h00;
      r_sc         <= '0;
      r_ec         <= CW'(H_RES - 1);
      r_sp         <= '0;
      r_ep         <= CW'(V_RES - 1);
      r_x          <= '0;
      r_y          <= '0;
      o_pix_valid  <= 1'b0;
      o_pix_x      <= '0;
      o_pix_y      <= '0;
      o_pix_data   <= 16'h0000;
      o_cmd_valid  <= 1'b0;
      o_cmd_code   <= 8'h00;
      o_frame_done <= 1'b0;
      o_err_win    <= 1'b0;
      o_err_rd     <= 1'b0;
    end else if (!r_lrst_s2) begin
      r_state      <= S_IDLE;
      r_idx        <= 2'd0;
      r_p0         <= 8'h00;
      r_p1         <= 8'h00;
      r_p2         <= 8'h00;
      r_sc         <= '0;
      r_ec         <= CW'(H_RES - 1);
      r_sp         <= '0;
      r_ep         <= CW'(V_RES - 1);
      r_x          <= '0;
      r_y          <= '0;
      o_pix_valid  <= 1'b0;
      o_pix_x      <= '0;
      o_pix_y      <= '0;
      o_pix_data   <= 16'h0000;
      o_cmd_valid  <= 1'b0;
      o_cmd_code   <= 8'h00;
      o_frame_done <= 1'b0;
      o_err_win    <= 1'b0;
      o_err_rd     <= 1'b0;
    end else begin
      o_pix_valid  <= 1'b0;
      o_cmd_valid  <= 1'b0;
      o_frame_done <= 1'b0;
      if (!r_rd_s2) begin
        o_err_rd <= 1'b1;
      end
      if (w_cmd) begin
        o_cmd_valid <= 1'b1;
        o_cmd_code  <= r_data_s2[7:0];
        r_idx       <= 2'd0;
        case (r_data_s2[7:0])
          8'h2A: r_state <= S_CASET;
          8'h2B: r_state <= S_PASET;
          8'h2C: begin
            r_state <= S_RAMWR;
            r_x     <= r_sc;
            r_y     <= r_sp;
          end
          8'h01: begin
            r_state <= S_IDLE;
            r_sc    <= '0;
            r_ec    <= CW'(H_RES - 1);
            r_sp    <= '0;
            r_ep    <= CW'(V_RES - 1);
          end
          default: r_state <= S_IDLE;
        endcase
      end else if (w_dat) begin
        case (r_state)
          S_CASET, S_PASET: begin
            r_idx <= r_idx + 2'd1;
            case (r_idx)
              2'd0: r_p0 <= r_data_s2[7:0];
              2'd1: r_p1 <= r_data_s2[7:0];
              2'd2: r_p2 <= r_data_s2[7:0];
              default: begin
                // Start and end commit together so a partial window is never visible.
                if (r_state == S_CASET) begin
                  r_sc <= CW'(w_start);
                  r_ec <= CW'(w_end);
                end else begin
                  r_sp <= CW'(w_start);
                  r_ep <= CW'(w_end);
                end
                r_state <= S_IDLE;
              end
            endcase
          end
          S_RAMWR: begin
            if (w_win_ok) begin
              o_pix_x      <= r_x;
              o_pix_y      <= r_y;
              o_pix_data   <= r_data_s2;
              o_pix_valid  <= w_in_bounds;
              o_frame_done <= w_last_col && w_last_row;
              if (w_last_col) begin
                r_x <= r_sc;
                r_y <= w_last_row ? r_sp : r_y + CW'(1);
              end else begin
                r_x <= r_x + CW'(1);
              end
            end else begin
              o_err_win <= 1'b1;
            end
          end
          default: r_state <= r_state;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_lcd_bus_decoder.sv
// Randomized bus-master bench for lcd_bus_decoder, checked against a
// behavioural panel model (window arithmetic on plain integers).
module tb_lcd_bus_decoder;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [15:0] lcd_data = 16'h0000;
  logic        lcd_dc = 1'b0, lcd_wr = 1'b1, lcd_rd = 1'b1, lcd_reset_n = 1'b1;
  logic        pix_valid, cmd_valid, frame_done, err_win, err_rd;
  logic [15:0] pix_x, pix_y, pix_data;
  logic [7:0]  cmd_code;

  int n_cmp = 0;
  int n_bad = 0;

  // Model state
  int m_sc, m_ec, m_sp, m_ep, m_x, m_y, m_mode, m_code, m_err_win, m_err_rd;
  int m_par[$];

  always #5 clk = ~clk;

  lcd_bus_decoder dut (
    .i_clk(clk), .i_reset_n(reset_n), .i_lcd_data(lcd_data), .i_lcd_dc(lcd_dc),
    .i_lcd_wr(lcd_wr), .i_lcd_rd(lcd_rd), .i_lcd_reset_n(lcd_reset_n),
    .o_pix_valid(pix_valid), .o_pix_x(pix_x), .o_pix_y(pix_y), .o_pix_data(pix_data),
    .o_cmd_valid(cmd_valid), .o_cmd_code(cmd_code), .o_frame_done(frame_done),
    .o_err_win(err_win), .o_err_rd(err_rd)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_sc = 0; m_ec = 239; m_sp = 0; m_ep = 319;
    m_x = 0; m_y = 0; m_mode = 0; m_code = 0;
    m_err_win = 0; m_err_rd = 0;
    m_par.delete();
  endtask

  // One bus write with model prediction and cycle-exact output checks.
  task automatic bus_write(input bit dc, input int d);
    bit e_cmd = 0, e_pix = 0, e_fd = 0;
    int e_x = 0, e_y = 0;
    if (!dc) begin
      e_cmd = 1; m_code = d & 255; m_par.delete();
      case (m_code)
        'h2A: m_mode = 1;
        'h2B: m_mode = 2;
        'h2C: begin m_mode = 3; m_x = m_sc; m_y = m_sp; end
        'h01: begin m_mode = 0; m_sc = 0; m_ec = 239; m_sp = 0; m_ep = 319; end
        default: m_mode = 0;
      endcase
    end else if (m_mode == 1 || m_mode == 2) begin
      m_par.push_back(d & 255);
      if (m_par.size() == 4) begin
        if (m_mode == 1) begin
          m_sc = m_par[0] * 256 + m_par[1]; m_ec = m_par[2] * 256 + m_par[3];
        end else begin
          m_sp = m_par[0] * 256 + m_par[1]; m_ep = m_par[2] * 256 + m_par[3];
        end
        m_par.delete(); m_mode = 0;
      end
    end else if (m_mode == 3) begin
      if (m_sc > m_ec || m_sp > m_ep) m_err_win = 1;
      else begin
        e_pix = (m_x < 240) && (m_y < 320);
        e_x = m_x; e_y = m_y;
        e_fd = (m_x == m_ec) && (m_y == m_ep);
        if (m_x == m_ec) begin
          m_x = m_sc;
          m_y = (m_y == m_ep) ? m_sp : m_y + 1;
        end else m_x = m_x + 1;
      end
    end
    @(negedge clk); lcd_data = d[15:0]; lcd_dc = dc;
    repeat (3) @(negedge clk); lcd_wr = 1'b0;
    repeat (3) @(negedge clk); lcd_wr = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    chk("early_pix", pix_valid, 0);
    chk("early_cmd", cmd_valid, 0);
    @(posedge clk); #1;
    chk("pix_valid", pix_valid, e_pix);
    chk("cmd_valid", cmd_valid, e_cmd);
    chk("cmd_code", cmd_code, m_code);
    chk("frame_done", frame_done, e_fd);
    chk("err_win", err_win, m_err_win);
    chk("err_rd", err_rd, m_err_rd);
    if (e_pix) begin
      chk("pix_x", pix_x, e_x);
      chk("pix_y", pix_y, e_y);
      chk("pix_data", pix_data, d & 32'hFFFF);
    end
    @(posedge clk); #1;
    chk("pulse_pix", pix_valid, 0);
    chk("pulse_cmd", cmd_valid, 0);
    chk("pulse_fd", frame_done, 0);
  endtask

  task automatic par(input int v);
    bus_write(1'b1, ($urandom & 32'hFF00) | (v & 255));
  endtask

  task automatic set_win(input int c, input int s, input int e);
    bus_write(1'b0, c);
    par(s >> 8); par(s); par(e >> 8); par(e);
  endtask

  task automatic ramwr(input int n, input int base);
    bus_write(1'b0, 'h2C);
    for (int i = 0; i < n; i++) bus_write(1'b1, (base == 0) ? $urandom_range(0, 65535) : base * (i + 1));
  endtask

  initial begin
    int r, s, e;
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_pix_valid", pix_valid, 0);
    chk("rst_cmd_code", cmd_code, 0);
    chk("rst_err", {err_win, err_rd}, 0);
    reset_n = 1'b1;
    repeat (4) @(negedge clk);

    // Hard reset mid-RAMWR, then first pixel lands at origin.
    bus_write(1'b0, 'h2C);
    bus_write(1'b1, 'h1234);
    @(negedge clk); reset_n = 1'b0; #1;
    chk("hrst_outs", {pix_valid, cmd_valid, frame_done, err_win, err_rd, cmd_code, pix_x, pix_y, pix_data}, 0);
    repeat (3) @(negedge clk); reset_n = 1'b1; model_reset();
    repeat (4) @(negedge clk);
    ramwr(1, 'hABCD);

    // Small window, exact frame then wrap.
    set_win('h2A, 10, 12);
    set_win('h2B, 5, 6);
    ramwr(6, 'h1111);
    ramwr(8, 'h1111);
    // Right-edge clipping with cursor wrap.
    set_win('h2A, 230, 245);
    ramwr(16, 0);
    // Interrupted CASET keeps the old window.
    bus_write(1'b0, 'h2A); par(0); par(50);
    ramwr(3, 0);
    // Inverted window.
    set_win('h2A, 20, 10);
    ramwr(2, 0);
    // Read strobe.
    @(negedge clk); lcd_rd = 1'b0;
    repeat (4) @(negedge clk); lcd_rd = 1'b1;
    repeat (3) @(posedge clk); #1;
    chk("err_rd_set", err_rd, 1);
    m_err_rd = 1;
    // Panel reset for 5 clocks.
    @(negedge clk); lcd_reset_n = 1'b0;
    repeat (5) @(negedge clk);
    chk("lrst_errs", {err_win, err_rd}, 0);
    lcd_reset_n = 1'b1; model_reset();
    repeat (4) @(negedge clk);
    ramwr(2, 'h0F0F);

    // Randomized sequences.
    for (int it = 0; it < 30; it++) begin
      r = $urandom_range(0, 11);
      if (r <= 2) begin
        s = $urandom_range(0, 300);
        e = ($urandom_range(0, 7) == 0 && s > 0) ? s - 1 : s + $urandom_range(0, 4);
        set_win('h2A, s, e);
      end else if (r <= 4) begin
        s = $urandom_range(0, 322);
        e = ($urandom_range(0, 7) == 0 && s > 0) ? s - 1 : s + $urandom_range(0, 3);
        set_win('h2B, s, e);
      end else if (r == 5) begin
        bus_write(1'b0, 'h2B); par($urandom_range(0, 255));
        bus_write(1'b0, ($urandom_range(0, 1) == 0) ? 'h36 : 'h01);
        par($urandom_range(0, 255));
      end else begin
        ramwr($urandom_range(1, 12), 0);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
